// File: rtl/tmg_window_gen.sv
// tmg_window_gen: parametrised im2col window generator.
// Reads a FM_W x FM_H feature map from a synchronous single-port RAM and
// streams every KxK window (order oy, ox, ky, kx; kx innermost) as a flat
// element sequence. Each element goes through a 2-entry output FIFO.
// Optional build macro: TMG_ZERO_PAD_EN adds a one-element zero border.
// Padded elements never touch the RAM but keep the same latency and order.
//
// Handshake: an element transfers on a rising edge where m_valid && m_ready.
// m_valid stays high and m_data/m_last_win/m_last stay stable until that
// transfer happens. m_valid never depends on m_ready.
// dbg_state exposes the FSM state (0 idle, 1 run, 2 drain, 3 done).
module tmg_window_gen #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned FM_W   = 8,
  parameter int unsigned FM_H   = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last_win,
  output logic          m_last,
  output logic [1:0]    dbg_state
);

`ifdef TMG_ZERO_PAD_EN
  localparam int unsigned PAD = 1;
`else
  localparam int unsigned PAD = 0;
`endif

  localparam int unsigned OH = (FM_H + 2 * PAD - K) / STRIDE + 1;
  localparam int unsigned OW = (FM_W + 2 * PAD - K) / STRIDE + 1;
  localparam int unsigned CW = 16;

  localparam logic [CW-1:0] K_M1  = CW'(K - 1);
  localparam logic [CW-1:0] OW_M1 = CW'(OW - 1);
  localparam logic [CW-1:0] OH_M1 = CW'(OH - 1);

  generate
    if (K < 1 || STRIDE < 1 || K > FM_W || K > FM_H) begin : g_bad_geometry
      $error("tmg_window_gen: illegal K/STRIDE/map geometry");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          last;
    logic          last_win;
    logic [DW-1:0] data;
  } entry_t;

  state_t        state, state_n;
  logic [AW-1:0] base_q;
  logic [CW-1:0] oy, ox, ky, kx;

  logic [31:0]   row_p, col_p, src_row, src_col;
  logic          in_map;
  logic [AW-1:0] rd_addr;
  logic          kx_end, ky_end, ox_end, oy_end;
  logic          elem_last_win, elem_last;

  logic          pend;       // one element in flight (read or padded)
  logic          pend_pad;
  logic          pend_lw;
  logic          pend_last;

  entry_t        mem [2];
  entry_t        push_ent;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic          pop;
  logic [1:0]    slots;
  logic          issue;
  logic          accept;

  assign accept = (state == S_IDLE) && start;

  // Map the window counters to a source coordinate and RAM address.
  always_comb begin
    row_p = 32'(oy) * STRIDE + 32'(ky);
    col_p = 32'(ox) * STRIDE + 32'(kx);
`ifdef TMG_ZERO_PAD_EN
    // Padded coordinates are offset by one; 0 and FM_x+1 are the zero border.
    in_map  = (row_p >= 32'd1) && (row_p <= FM_H) &&
              (col_p >= 32'd1) && (col_p <= FM_W);
    src_row = row_p - 32'd1;
    src_col = col_p - 32'd1;
`else
    in_map  = 1'b1;
    src_row = row_p;
    src_col = col_p;
`endif
    // Address wraps modulo 2^AW by truncation.
    rd_addr = AW'(32'(base_q) + src_row * FM_W + src_col);
  end

  assign kx_end        = (kx == K_M1);
  assign ky_end        = (ky == K_M1);
  assign ox_end        = (ox == OW_M1);
  assign oy_end        = (oy == OH_M1);
  assign elem_last_win = kx_end && ky_end;
  assign elem_last     = elem_last_win && ox_end && oy_end;

  // Credit check: a slot freed by a pop this cycle may be reused, which is
  // what sustains one element per cycle; occupancy plus in-flight never
  // exceeds the two FIFO entries.
  assign pop    = m_valid && m_ready;
  assign slots  = count + {1'b0, pend} - {1'b0, pop};
  assign issue  = (state == S_RUN) && (slots < 2'd2);
  assign ram_rd = issue && in_map;
  assign ram_addr = ram_rd ? rd_addr : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state plus busy/done decode.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue && elem_last) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (count == 2'd0 && !pend) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Latch the map origin when a pass is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         base_q <= '0;
    else if (accept) base_q <= base_addr;
  end

  // Window counters advance only when an element is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (accept) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (issue) begin
      if (!kx_end) begin
        kx <= kx + 1'b1;
      end else begin
        kx <= '0;
        if (!ky_end) begin
          ky <= ky + 1'b1;
        end else begin
          ky <= '0;
          if (!ox_end) begin
            ox <= ox + 1'b1;
          end else begin
            ox <= '0;
            oy <= oy_end ? '0 : oy + 1'b1;
          end
        end
      end
    end
  end

  // Track the element in flight and its sideband flags for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_pad  <= 1'b0;
      pend_lw   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= issue;
      pend_pad  <= issue && !in_map;
      pend_lw   <= elem_last_win;
      pend_last <= elem_last;
    end
  end

  assign push_ent.data     = pend_pad ? '0 : ram_dout;
  assign push_ent.last_win = pend_lw;
  assign push_ent.last     = pend_last;

  // Two-entry output FIFO; push and pop in one cycle leave occupancy as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pend) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, pend} - {1'b0, pop};
    end
  end

  assign m_valid    = (count != 2'd0);
  assign m_data     = mem[rd_ptr].data;
  assign m_last_win = mem[rd_ptr].last_win;
  assign m_last     = mem[rd_ptr].last;

endmodule

// File: tb/tb_tmg_window_gen.sv
// Bench for tmg_window_gen: instance a = 4x4 map K=3 STRIDE=1,
// instance b = 5x5 map K=3 STRIDE=2. Expected element streams come from a
// loop-nest model of the window walk over a RAM holding RAM[i]=i.
module tb_tmg_window_gen;
  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_a, start_b;
  logic [AW-1:0] base_addr;
  logic          m_ready;

  logic          busy_a, done_a, ram_rd_a, m_valid_a, m_last_win_a, m_last_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_dout_a, m_data_a;
  logic [1:0]    dbg_state_a;

  logic          busy_b, done_b, ram_rd_b, m_valid_b, m_last_win_b, m_last_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b, m_data_b;
  logic [1:0]    dbg_state_b;

  tmg_window_gen #(.DW(DW), .AW(AW), .FM_W(4), .FM_H(4), .K(3), .STRIDE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
    .busy(busy_a), .done(done_a), .ram_rd(ram_rd_a), .ram_addr(ram_addr_a),
    .ram_dout(ram_dout_a), .m_data(m_data_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_last_win(m_last_win_a), .m_last(m_last_a),
    .dbg_state(dbg_state_a)
  );

  tmg_window_gen #(.DW(DW), .AW(AW), .FM_W(5), .FM_H(5), .K(3), .STRIDE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
    .busy(busy_b), .done(done_b), .ram_rd(ram_rd_b), .ram_addr(ram_addr_b),
    .ram_dout(ram_dout_b), .m_data(m_data_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_last_win(m_last_win_b), .m_last(m_last_b),
    .dbg_state(dbg_state_b)
  );

  // Synchronous RAM model shared by both instances, one read port each.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_rd_a) ram_dout_a <= ram[ram_addr_a];
    if (ram_rd_b) ram_dout_b <= ram[ram_addr_b];
  end

  // ---------------- scoreboard state ----------------
  logic [DW+1:0] exp_q[$];    // {last, last_win, data}
  int            exp_rd;
  int            n_vec = 0;
  int            n_err = 0;
  int            rd_cnt, done_cnt, xfer_cnt;
  bit            sel;          // 0 = instance a, 1 = instance b
  bit            rand_ready;
  bit            seen_valid;
  bit            hold_pend;
  logic [DW+1:0] held;

  logic          mon_valid, mon_busy, mon_done, mon_rd;
  logic [DW+1:0] mon_word;
  assign mon_valid = sel ? m_valid_b : m_valid_a;
  assign mon_busy  = sel ? busy_b    : busy_a;
  assign mon_done  = sel ? done_b    : done_a;
  assign mon_rd    = sel ? ram_rd_b  : ram_rd_a;
  assign mon_word  = sel ? {m_last_b, m_last_win_b, m_data_b}
                         : {m_last_a, m_last_win_a, m_data_a};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected stream for one pass of the selected instance.
  task automatic build_exp(input bit inst, input logic [AW-1:0] base);
    int fw, fh, k, s, pad, oh, ow, r, c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic lw, ls;
    fw = inst ? 5 : 4;
    fh = fw;
    k  = 3;
    s  = inst ? 2 : 1;
`ifdef TMG_ZERO_PAD_EN
    pad = 1;
`else
    pad = 0;
`endif
    oh = (fh + 2 * pad - k) / s + 1;
    ow = (fw + 2 * pad - k) / s + 1;
    exp_q.delete();
    exp_rd = 0;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            r = oy * s + ky - pad;
            c = ox * s + kx - pad;
            if (r < 0 || r >= fh || c < 0 || c >= fw) begin
              d = '0;
            end else begin
              a = AW'(int'(base) + r * fw + c);
              d = ram[a];
              exp_rd++;
            end
            lw = (ky == k - 1) && (kx == k - 1);
            ls = lw && (oy == oh - 1) && (ox == ow - 1);
            exp_q.push_back({ls, lw, d});
          end
  endtask

  // Output monitor: compares transfers, stall stability, bubbles, done.
  always @(negedge clk) begin
    if (!rst) begin
      if (mon_rd) rd_cnt++;
      if (mon_done) begin
        done_cnt++;
        check("busy_at_done", 64'(mon_busy), 64'(0));
      end
      if (hold_pend) check("stall_hold", 64'({mon_valid, mon_word}), 64'({1'b1, held}));
      hold_pend = mon_valid && !m_ready;
      held      = mon_word;
      if (!rand_ready && seen_valid && exp_q.size() > 0)
        check("no_bubble", 64'(mon_valid), 64'(1));
      if (mon_valid) seen_valid = 1'b1;
      if (mon_valid && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("extra_element", 64'(exp_q.size()), 64'(1));
        else                   check("element", 64'(mon_word), 64'(exp_q.pop_front()));
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Downstream ready: held high or random 50% per cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit inst, input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    base_addr = base;
    if (inst) start_b = 1'b1;
    else      start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_pass(input bit inst, input logic [AW-1:0] base, input bit rnd,
                          input bit mid_start);
    bit got_done;
    sel        = inst;
    rand_ready = rnd;
    seen_valid = 1'b0;
    build_exp(inst, base);
    rd_cnt   = 0;
    done_cnt = 0;
    xfer_cnt = 0;
    pulse_start(inst, base);
    if (!rnd) begin
      @(negedge clk);
      check("busy_after_start", 64'(mon_busy), 64'(1));
      check("valid_cycle0", 64'(mon_valid), 64'(0));
      @(negedge clk);
      check("valid_cycle1", 64'(mon_valid), 64'(0));
      @(negedge clk);
      check("valid_cycle2", 64'(mon_valid), 64'(1));
    end
    got_done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(posedge clk);
      #1;
      if (mid_start && cyc == 15) begin
        base_addr = 8'd77;
        if (inst) start_b = 1'b1;
        else      start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(negedge clk);
      if (done_cnt > 0) got_done = 1'b1;
    end
    check("done_seen", 64'(got_done), 64'(1));
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("ram_rd_count", 64'(rd_cnt), 64'(exp_rd));
    check("busy_idle", 64'(mon_busy), 64'(0));
    check("valid_idle", 64'(mon_valid), 64'(0));
  endtask

  task automatic reset_mid_pass();
    sel        = 1'b0;
    rand_ready = 1'b0;
    seen_valid = 1'b0;
    build_exp(1'b0, 8'd0);
    rd_cnt   = 0;
    done_cnt = 0;
    xfer_cnt = 0;
    pulse_start(1'b0, 8'd0);
    for (int cyc = 0; cyc < 200 && xfer_cnt < 10; cyc++) @(negedge clk);
    check("reach_elem10", 64'(xfer_cnt >= 10), 64'(1));
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_outputs", 64'({busy_a, done_a, ram_rd_a, ram_addr_a, m_data_a,
                                m_valid_a, m_last_win_a, m_last_a, dbg_state_a}), 64'(0));
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(0));
    check("abort_idle", 64'({busy_a, m_valid_a, dbg_state_a}), 64'(0));
    run_pass(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  // Time limit so a stuck design still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    base_addr  = '0;
    sel        = 1'b0;
    rand_ready = 1'b0;
    hold_pend  = 1'b0;
    held       = '0;
    ram_dout_a = '0;
    ram_dout_b = '0;
    rd_cnt     = 0;
    done_cnt   = 0;
    xfer_cnt   = 0;
    for (int i = 0; i < 256; i++) ram[i] = DW'(i);

    repeat (2) @(negedge clk);
    check("reset_outputs_a", 64'({busy_a, done_a, ram_rd_a, ram_addr_a, m_data_a,
                                  m_valid_a, m_last_win_a, m_last_a, dbg_state_a}), 64'(0));
    check("reset_outputs_b", 64'({busy_b, done_b, ram_rd_b, ram_addr_b, m_data_b,
                                  m_valid_b, m_last_win_b, m_last_b, dbg_state_b}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_pass(1'b0, 8'd0,   1'b0, 1'b0);  // 4x4, full rate
    run_pass(1'b0, 8'd0,   1'b1, 1'b1);  // 4x4, random ready, ignored start
    run_pass(1'b1, 8'd0,   1'b0, 1'b0);  // 5x5 stride 2
    run_pass(1'b0, 8'd250, 1'b1, 1'b0);  // address wrap
    reset_mid_pass();                     // abort then restart
    run_pass(1'b1, 8'd100, 1'b1, 1'b0);  // 5x5 stride 2, random ready

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
